// File: rtl/nn_mac_pipe.sv
// Pipelined signed dot-product MAC: full-precision products feed a wrapping
// accumulator; each vector's sum is rounded, shifted and saturated into a held result.
module nn_mac_pipe #(
   parameter int din0_WIDTH = 10,
   parameter int din1_WIDTH = 36,
   parameter int ACC_WIDTH  = 52,
   parameter int dout_WIDTH = 36,
   parameter int NUM_STAGE  = 2,
   parameter int SHIFT      = 0
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [din0_WIDTH-1:0] din0,
   input  logic signed [din1_WIDTH-1:0] din1,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [dout_WIDTH-1:0] dout,
   output logic                         dout_sat,
   output logic [15:0]                  dout_cnt
);
   localparam int PROD_W = din0_WIDTH + din1_WIDTH;
   // One spare bit above the larger of (acc + rounding carry) and dout.
   localparam int RND_W  = ((ACC_WIDTH + 1 > dout_WIDTH) ? ACC_WIDTH + 1 : dout_WIDTH) + 1;
   localparam int HALF_B = (SHIFT > 0) ? SHIFT - 1 : 0;

   function automatic logic signed [RND_W-1:0] round_shift(input logic signed [ACC_WIDTH-1:0] a);
      logic signed [RND_W-1:0] v;
      logic signed [RND_W-1:0] half;
      v            = RND_W'(a);
      half         = '0;
      half[HALF_B] = (SHIFT > 0);
      return (v + half) >>> SHIFT;
   endfunction

   // Returns {clipped, value}.
   function automatic logic [dout_WIDTH:0] saturate(input logic signed [RND_W-1:0] v);
      logic signed [RND_W-1:0] hi;
      logic signed [RND_W-1:0] lo;
      hi = '0;
      for (int i = 0; i < dout_WIDTH - 1; i++) hi[i] = 1'b1;
      lo = ~hi;
      if (v > hi) return {1'b1, hi[dout_WIDTH-1:0]};
      if (v < lo) return {1'b1, lo[dout_WIDTH-1:0]};
      return {1'b0, v[dout_WIDTH-1:0]};
   endfunction

   logic                     vld_q  [NUM_STAGE];
   logic                     vld_d  [NUM_STAGE];
   logic                     last_q [NUM_STAGE];
   logic                     last_d [NUM_STAGE];
   logic signed [PROD_W-1:0] prod_q [NUM_STAGE];
   logic signed [PROD_W-1:0] prod_d [NUM_STAGE];

   logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, sum;
   logic [15:0]                  cnt_q, cnt_d, cnt_inc;
   logic                         out_valid_q, out_valid_d;
   logic signed [dout_WIDTH-1:0] dout_q, dout_d;
   logic                         dout_sat_q, dout_sat_d;
   logic [15:0]                  dout_cnt_q, dout_cnt_d;
   logic [dout_WIDTH:0]          sat_res;
   logic                         adv;

   always_comb begin
      adv = !(out_valid_q && !out_ready);
      for (int i = 0; i < NUM_STAGE; i++) begin
         vld_d[i]  = vld_q[i];
         last_d[i] = last_q[i];
         prod_d[i] = prod_q[i];
      end
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      dout_sat_d  = dout_sat_q;
      dout_cnt_d  = dout_cnt_q;
      sum         = acc_q + ACC_WIDTH'(prod_q[NUM_STAGE-1]);
      cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      sat_res     = saturate(round_shift(sum));

      if (adv) begin
         // ---- stage 0: multiply; later stages just carry product and tags
         vld_d[0]  = in_valid;
         last_d[0] = in_last;
         prod_d[0] = PROD_W'(din0) * PROD_W'(din1);
         for (int i = 1; i < NUM_STAGE; i++) begin
            vld_d[i]  = vld_q[i-1];
            last_d[i] = last_q[i-1];
            prod_d[i] = prod_q[i-1];
         end

         // ---- pipeline exit: accumulate, and on last beat load the output stage
         out_valid_d = vld_q[NUM_STAGE-1] && last_q[NUM_STAGE-1];
         if (vld_q[NUM_STAGE-1]) begin
            if (last_q[NUM_STAGE-1]) begin
               acc_d      = '0;
               cnt_d      = '0;
               dout_d     = sat_res[dout_WIDTH-1:0];
               dout_sat_d = sat_res[dout_WIDTH];
               dout_cnt_d = cnt_inc;
            end else begin
               acc_d = sum;
               cnt_d = cnt_inc;
            end
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < NUM_STAGE; i++) vld_q[i] <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         dout_sat_q  <= 1'b0;
         dout_cnt_q  <= '0;
      end else begin
         for (int i = 0; i < NUM_STAGE; i++) vld_q[i] <= vld_d[i];
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         dout_sat_q  <= dout_sat_d;
         dout_cnt_q  <= dout_cnt_d;
      end
   end

   // Payload of the multiplier pipe is qualified by vld_q, so it needs no reset.
   always_ff @(posedge ap_clk) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
         last_q[i] <= last_d[i];
         prod_q[i] <= prod_d[i];
      end
   end

   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign dout_sat  = dout_sat_q;
   assign dout_cnt  = dout_cnt_q;

endmodule

// File: tb/tb_nn_mac_pipe.sv
// Scoreboard bench for nn_mac_pipe: three parameterisations driven one at a time,
// expected results from a plain-arithmetic dot-product model.
module tb_nn_mac_pipe;
   localparam int NSG [3] = '{2, 4, 1};
   localparam int SH  [3] = '{0, 4, 3};
   localparam int DW  [3] = '{36, 8, 20};

   typedef struct {
      int     k;
      longint val;
      bit     sat;
      int     cnt;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic               in_valid  [3];
   logic               in_last   [3];
   logic signed [9:0]  din0      [3];
   logic signed [35:0] din1      [3];
   logic               out_ready [3];
   logic               in_ready  [3];
   logic               out_valid [3];
   logic               dout_sat  [3];
   logic [15:0]        dout_cnt  [3];
   logic signed [35:0] dout_x    [3];
   logic signed [35:0] dout0;
   logic signed [7:0]  dout1;
   logic signed [19:0] dout2;

   bit     rdy_force [3];
   bit     rdy_val   [3];
   exp_t   sb[$];
   int     total = 0;
   int     bad   = 0;
   longint m_acc = 0;
   int     m_cnt = 0;

   always #5 clk = ~clk;

   assign dout_x[0] = dout0;
   assign dout_x[1] = {{28{dout1[7]}}, dout1};
   assign dout_x[2] = {{16{dout2[19]}}, dout2};

   nn_mac_pipe #(.NUM_STAGE(2), .SHIFT(0), .dout_WIDTH(36)) u0 (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .din0(din0[0]), .din1(din1[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .dout(dout0), .dout_sat(dout_sat[0]), .dout_cnt(dout_cnt[0]));

   nn_mac_pipe #(.NUM_STAGE(4), .SHIFT(4), .dout_WIDTH(8)) u1 (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .din0(din0[1]), .din1(din1[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .dout(dout1), .dout_sat(dout_sat[1]), .dout_cnt(dout_cnt[1]));

   nn_mac_pipe #(.NUM_STAGE(1), .SHIFT(3), .dout_WIDTH(20)) u2 (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .din0(din0[2]), .din1(din1[2]), .in_last(in_last[2]), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .dout(dout2), .dout_sat(dout_sat[2]), .dout_cnt(dout_cnt[2]));

   // Reference: round half up, arithmetic shift, clip to dout range.
   function automatic exp_t finalize(input int k, input longint s, input int cnt);
      exp_t   e;
      longint v;
      longint hi;
      v = s;
      if (SH[k] > 0) v = (v + (64'sd1 <<< (SH[k] - 1))) >>> SH[k];
      hi    = (64'sd1 <<< (DW[k] - 1)) - 64'sd1;
      e.k   = k;
      e.sat = 1'b0;
      if (v > hi) begin
         v = hi; e.sat = 1'b1;
      end else if (v < -hi - 64'sd1) begin
         v = -hi - 64'sd1; e.sat = 1'b1;
      end
      e.val = v;
      e.cnt = (cnt > 65535) ? 65535 : cnt;
      return e;
   endfunction

   task automatic chk(input string name, input int k, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s inst=%0d: got %0d, required %0d", name, k, act, req);
      end
   endtask

   task automatic idle(input int k, input int n);
      in_valid[k] = 1'b0;
      din0[k]     = 10'($urandom);
      din1[k]     = 36'({$urandom, $urandom});
      in_last[k]  = 1'($urandom_range(0, 1));
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_beat(input int k, input longint a, input longint b, input bit last);
      bit took;
      int guard;
      took        = 1'b0;
      guard       = 0;
      in_valid[k] = 1'b1;
      din0[k]     = a[9:0];
      din1[k]     = b[35:0];
      in_last[k]  = last;
      while (!took && guard < 2000) begin
         @(negedge clk);
         took = in_ready[k];
         @(posedge clk); #1;
         guard++;
      end
      in_valid[k] = 1'b0;
      if (!took) begin
         total++; bad++;
         $display("FAIL accept_timeout inst=%0d: in_ready stayed 0, required 1", k);
      end else begin
         m_acc = m_acc + longint'(din0[k]) * longint'(din1[k]);
         m_acc = (m_acc <<< 12) >>> 12;
         m_cnt++;
         if (last) begin
            sb.push_back(finalize(k, m_acc, m_cnt));
            m_acc = 0;
            m_cnt = 0;
         end
      end
   endtask

   task automatic wait_out(input int k, output int lat);
      lat = 0;
      while (out_valid[k] !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (out_valid[k] !== 1'b1) begin
         total++; bad++;
         $display("FAIL out_timeout inst=%0d: out_valid stayed 0, required 1", k);
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sb.size() != 0 && g < 3000) begin
         @(posedge clk); #1;
         g++;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d results outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic rdy_driver();
      forever begin
         @(posedge clk); #1;
         for (int k = 0; k < 3; k++)
            out_ready[k] = rdy_force[k] ? rdy_val[k] : ($urandom_range(0, 99) < 70);
      end
   endtask

   task automatic monitor();
      bit     held [3];
      longint hv   [3];
      bit     hs   [3];
      int     hc   [3];
      exp_t   e;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (rst_n !== 1'b1 || out_valid[k] !== 1'b1) begin
               held[k] = 1'b0;
            end else begin
               if (held[k]) begin
                  total++;
                  if (longint'(dout_x[k]) != hv[k] || dout_sat[k] != hs[k] || int'(dout_cnt[k]) != hc[k]) begin
                     bad++;
                     $display("FAIL hold_stable inst=%0d: dout=%0d sat=%0d cnt=%0d, required dout=%0d sat=%0d cnt=%0d",
                              k, dout_x[k], dout_sat[k], dout_cnt[k], hv[k], hs[k], hc[k]);
                  end
               end
               if (out_ready[k]) begin
                  held[k] = 1'b0;
                  total++;
                  if (sb.size() == 0) begin
                     bad++;
                     $display("FAIL unexpected_result inst=%0d: dout=%0d cnt=%0d, required no result", k, dout_x[k], dout_cnt[k]);
                  end else begin
                     e = sb.pop_front();
                     if (e.k != k || longint'(dout_x[k]) != e.val || dout_sat[k] != e.sat || int'(dout_cnt[k]) != e.cnt) begin
                        bad++;
                        $display("FAIL result inst=%0d: dout=%0d sat=%0d cnt=%0d, required inst=%0d dout=%0d sat=%0d cnt=%0d",
                                 k, dout_x[k], dout_sat[k], dout_cnt[k], e.k, e.val, e.sat, e.cnt);
                     end
                  end
               end else begin
                  held[k] = 1'b1;
                  hv[k]   = longint'(dout_x[k]);
                  hs[k]   = dout_sat[k];
                  hc[k]   = int'(dout_cnt[k]);
               end
            end
         end
      end
   endtask

   initial begin
      int lat;
      int beats;
      int len;
      longint a;
      longint b;
      for (int k = 0; k < 3; k++) begin
         in_valid[k]  = 1'b0;
         in_last[k]   = 1'b0;
         din0[k]      = '0;
         din1[k]      = '0;
         out_ready[k] = 1'b1;
         rdy_force[k] = 1'b1;
         rdy_val[k]   = 1'b1;
      end
      fork
         monitor();
         rdy_driver();
      join_none

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_out_valid", k, out_valid[k], 0);
         chk("rst_in_ready", k, in_ready[k], 1);
         chk("rst_dout", k, dout_x[k], 0);
         chk("rst_dout_sat", k, dout_sat[k], 0);
         chk("rst_dout_cnt", k, dout_cnt[k], 0);
      end

      // Basic dot product and latency on the default configuration.
      send_beat(0, 3, 4, 1'b0);
      send_beat(0, -2, 5, 1'b0);
      send_beat(0, 7, -1, 1'b1);
      wait_out(0, lat);
      chk("latency", 0, lat, NSG[0]);
      chk("dot_dout", 0, dout_x[0], -5);
      chk("dot_cnt", 0, dout_cnt[0], 3);
      chk("dot_sat", 0, dout_sat[0], 0);
      drain();

      // Rounding and clipping with an 8-bit result.
      send_beat(1, 100, 100, 1'b1);
      wait_out(1, lat);
      chk("latency", 1, lat, NSG[1]);
      chk("clip_hi_dout", 1, dout_x[1], 127);
      chk("clip_hi_sat", 1, dout_sat[1], 1);
      chk("single_cnt", 1, dout_cnt[1], 1);
      drain();
      send_beat(1, -200, 100, 1'b1);
      wait_out(1, lat);
      chk("clip_lo_dout", 1, dout_x[1], -128);
      chk("clip_lo_sat", 1, dout_sat[1], 1);
      drain();

      // Backpressure: two vectors while the consumer is stalled.
      rdy_val[0] = 1'b0;
      fork
         begin
            send_beat(0, 3, 4, 1'b0);
            send_beat(0, -2, 5, 1'b0);
            send_beat(0, 7, -1, 1'b1);
            send_beat(0, 10, 10, 1'b0);
            send_beat(0, -3, 3, 1'b0);
            send_beat(0, 2, 2, 1'b1);
         end
         begin
            repeat (15) begin
               @(posedge clk); #1;
            end
            chk("bp_in_ready_low", 0, in_ready[0], 0);
            chk("bp_out_valid", 0, out_valid[0], 1);
            chk("bp_held_dout", 0, dout_x[0], -5);
            repeat (5) begin
               @(posedge clk); #1;
            end
            chk("bp_still_held", 0, dout_x[0], -5);
            rdy_val[0] = 1'b1;
         end
      join
      drain();

      // Reset in the middle of a vector discards it.
      send_beat(0, 5, 5, 1'b0);
      send_beat(0, 6, 6, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      m_acc = 0;
      m_cnt = 0;
      chk("mid_rst_out_valid", 0, out_valid[0], 0);
      chk("mid_rst_in_ready", 0, in_ready[0], 1);
      send_beat(0, 1, 1, 1'b0);
      send_beat(0, 1, 1, 1'b1);
      wait_out(0, lat);
      chk("after_rst_dout", 0, dout_x[0], 2);
      chk("after_rst_cnt", 0, dout_cnt[0], 2);
      drain();

      // Random vectors with bubbles and random consumer readiness.
      for (int k = 0; k < 3; k++) begin
         rdy_force[k] = 1'b0;
         beats = 0;
         while (beats < 3400) begin
            len = $urandom_range(1, 64);
            for (int j = 0; j < len; j++) begin
               if ($urandom_range(0, 9) < 3) idle(k, $urandom_range(1, 3));
               a = ($urandom_range(0, 1) == 1) ? longint'($urandom) : longint'($urandom_range(0, 6)) - 64'sd3;
               b = ($urandom_range(0, 1) == 1) ? longint'({$urandom, $urandom})
                                               : longint'($urandom_range(0, 2000000)) - 64'sd1000000;
               send_beat(k, a, b, j == len - 1);
               beats++;
            end
         end
         rdy_force[k] = 1'b1;
         rdy_val[k]   = 1'b1;
         drain();
      end

      repeat (10) begin
         @(posedge clk); #1;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nn_mac_pipe.md
NN_MAC_PIPE -- requirements
Module: NN_mac_pipe

Interface
REQ-001 The module SHALL have parameter din0_WIDTH, default 10, signed width of operand A.
REQ-002 The module SHALL have parameter din1_WIDTH, default 36, signed width of operand B.
REQ-003 The module SHALL have parameter ACC_WIDTH, default 52, signed accumulator width; it SHALL be at least din0_WIDTH+din1_WIDTH.
REQ-004 The module SHALL have parameter dout_WIDTH, default 36, signed result width.
REQ-005 The module SHALL have parameter NUM_STAGE, default 2, range 1..4, multiplier pipeline depth in cycles.
REQ-006 The module SHALL have parameter SHIFT, default 0, range 0..ACC_WIDTH-1, arithmetic right shift applied to the final sum.
REQ-007 ap_clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 ap_rst_n  input  1  reset; synchronous, active-low.
REQ-009 in_valid  input  1  beat on din0/din1/in_last is valid.
REQ-010 in_ready  output  1  block accepts a beat this cycle.
REQ-011 din0  input  din0_WIDTH  signed operand A.
REQ-012 din1  input  din1_WIDTH  signed operand B.
REQ-013 in_last  input  1  final beat of the current dot product.
REQ-014 out_valid  output  1  dout/dout_sat/dout_cnt are valid.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 dout  output  dout_WIDTH  rounded, saturated dot-product result.
REQ-017 dout_sat  output  1  high when dout was clipped.
REQ-018 dout_cnt  output  16  number of beats accumulated into dout.

Function
REQ-019 A beat SHALL be accepted when in_valid and in_ready are both high.
REQ-020 Advance signal adv = !(out_valid && !out_ready); in_ready SHALL equal adv; when adv is low, the multiplier pipeline, accumulator and counter SHALL hold.
REQ-021 The product SHALL be the full-precision signed din0*din1 (din0_WIDTH+din1_WIDTH bits), carried with its valid and last tags through NUM_STAGE registers.
REQ-022 On a pipeline-exit beat, the accumulator SHALL add the sign-extended product; accumulation wraps modulo 2^ACC_WIDTH without a flag.
REQ-023 On a pipeline-exit beat with last tag, the accumulator and beat counter SHALL restart from zero on the next beat (first beat of the next vector loads its product directly).
REQ-024 Final sum processing: if SHIFT>0, add 2^(SHIFT-1) then arithmetic shift right by SHIFT (round half up); if SHIFT=0, no change.
REQ-025 The shifted value SHALL saturate to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1]; dout_sat high exactly when clipping occurred.
REQ-026 The result SHALL be registered into the output stage in the cycle the last beat exits the pipeline; out_valid rises the following cycle.
REQ-027 Latency, no stall: last beat accepted at cycle t -> out_valid high at cycle t+NUM_STAGE+1.
REQ-028 out_valid, dout, dout_sat, dout_cnt SHALL stay stable until out_valid && out_ready; with out_ready high, back-to-back results SHALL issue with no bubble.
REQ-029 dout_cnt SHALL saturate at 65535.
REQ-030 A single-beat vector (in_valid && in_last on the first beat) SHALL yield dout = processed din0*din1, dout_cnt = 1.
REQ-031 Beats with in_valid low SHALL insert bubbles that neither add to the accumulator nor increment the counter.

Reset
REQ-032 While ap_rst_n is low at a clock edge, all pipeline valid tags, accumulator, counter, out_valid, dout, dout_sat, dout_cnt SHALL clear to 0; in_ready SHALL be 1 the cycle after reset deasserts.
REQ-033 Reset mid-vector SHALL discard the partial sum and all in-flight beats; no result SHALL be emitted for them.

Verification
REQ-034 Defaults, out_ready=1: beats (3,4),(−2,5),(7,−1,last) -> out_valid at t_last+3, dout=-5, dout_cnt=3, dout_sat=0.
REQ-035 SHIFT=4, dout_WIDTH=8: single beat (100,100,last) -> 10000+8>>4 = 625 clipped -> dout=127, dout_sat=1; (-200,100,last) -> dout=-128, dout_sat=1.
REQ-036 Backpressure: out_ready=0 while two vectors stream -> in_ready falls once the first result is held, first result stable until out_ready=1, second result correct, no beat lost or duplicated.
REQ-037 Reset after 2 of 4 beats, then new vector (1,1),(1,1,last) -> dout=2, dout_cnt=2; no stale output.
REQ-038 Random: 10k beats, random vector lengths 1..64, random in_valid/out_ready, NUM_STAGE in {1,4} -> every result matches reference model bit-exact.
